// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter sharing one RAM port between the core
// (requester 0) and the SPI engine (requester 1), with bounded lock priority.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_LOCK   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic                  r0_lock,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   output logic                  r0_done,
   output logic [DATA_WIDTH-1:0] r0_rdata,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic                  r1_lock,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   output logic                  r1_done,
   output logic [DATA_WIDTH-1:0] r1_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   localparam int LCW = ($clog2(MAX_LOCK + 1) > 2) ? $clog2(MAX_LOCK + 1) : 2;
   localparam logic [LCW-1:0] MAX_LOCK_C = LCW'(MAX_LOCK);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]            state_q,     state_d;
   logic                  winner_q,    winner_d;
   logic                  win_lock_q,  win_lock_d;
   logic                  last_gnt_q,  last_gnt_d;
   logic                  prev_lock_q, prev_lock_d;
   logic [LCW-1:0]        lock_cnt_q,  lock_cnt_d;
   logic                  mem_en_q,    mem_en_d;
   logic                  mem_we_q,    mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]            done_q,      done_d;
   logic [DATA_WIDTH-1:0] rdata0_q,    rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q,    rdata1_d;
   logic                  busy_q,      busy_d;
   logic                  win_c;

   // Winner selection and next-state computation for the IDLE/ISSUE/DONE FSM.
   always_comb begin
      state_d     = state_q;
      winner_d    = winner_q;
      win_lock_d  = win_lock_q;
      last_gnt_d  = last_gnt_q;
      prev_lock_d = prev_lock_q;
      lock_cnt_d  = lock_cnt_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = done_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      win_c       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (r0_req || r1_req) begin
               if (r0_req && !r1_req)
                  win_c = 1'b0;
               else if (r1_req && !r0_req)
                  win_c = 1'b1;
               else if (prev_lock_q && (lock_cnt_q < MAX_LOCK_C))
                  win_c = last_gnt_q;
               else
                  win_c = ~last_gnt_q;
               winner_d    = win_c;
               win_lock_d  = win_c ? r1_lock  : r0_lock;
               mem_en_d    = 1'b1;
               mem_we_d    = win_c ? r1_we    : r0_we;
               mem_addr_d  = win_c ? r1_addr  : r0_addr;
               mem_wdata_d = win_c ? r1_wdata : r0_wdata;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!mem_we_q) begin
               if (winner_q) rdata1_d = mem_rdata;
               else          rdata0_d = mem_rdata;
            end
            mem_en_d         = 1'b0;
            mem_we_d         = 1'b0;
            done_d[winner_q] = 1'b1;
            state_d          = S_DONE;
         end
         S_DONE: begin
            done_d      = 2'b00;
            last_gnt_d  = winner_q;
            prev_lock_d = win_lock_q;
            // lock_cnt counts grants won through the lock (the first locked
            // access that opened the run is not counted), so a locked requester
            // gets MAX_LOCK extra back-to-back grants before round-robin.
            if ((winner_q == last_gnt_q) && win_lock_q && prev_lock_q) begin
               if (lock_cnt_q < MAX_LOCK_C)
                  lock_cnt_d = lock_cnt_q + LCW'(1);
            end else begin
               lock_cnt_d = '0;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         winner_q    <= 1'b0;
         win_lock_q  <= 1'b0;
         last_gnt_q  <= 1'b1;
         prev_lock_q <= 1'b0;
         lock_cnt_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 2'b00;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         win_lock_q  <= win_lock_d;
         last_gnt_q  <= last_gnt_d;
         prev_lock_q <= prev_lock_d;
         lock_cnt_q  <= lock_cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         busy_q      <= busy_d;
      end
   end

   assign r0_done   = done_q[0];
   assign r1_done   = done_q[1];
   assign r0_rdata  = rdata0_q;
   assign r1_rdata  = rdata1_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural RAM model.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
   logic [7:0]  r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata;
   logic        r0_done, r1_done;
   logic [31:0] r0_rdata, r1_rdata;
   logic        mem_en, mem_we, busy;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic [31:0] ram [0:255];

   int errors = 0;
   int checks = 0;

   ram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_LOCK(4)) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_done(r0_done), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_done(r1_done), .r1_rdata(r1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM model: combinational read, write at posedge; reset reloads contents.
   assign mem_rdata = ram[mem_addr];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
         ram[8'h10] <= 32'hDEADBEEF;
         ram[8'hFF] <= 32'hCAFEF00D;
         ram[8'h00] <= 32'h11111111;
         ram[8'h01] <= 32'h01010101;
         ram[8'h02] <= 32'h02020202;
      end else if (mem_en && mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
   end

   typedef struct {
      bit          who;
      bit          we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
      r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Single uncontended access with cycle-exact checks at t+1, t+2, t+3.
   task automatic do_access(input vec_t v);
      if (v.who == 1'b0) begin
         r0_req = 1; r0_we = v.we; r0_addr = v.addr; r0_wdata = v.wdata;
      end else begin
         r1_req = 1; r1_we = v.we; r1_addr = v.addr; r1_wdata = v.wdata;
      end
      tick();
      chk("issue_mem_en", {31'b0, mem_en}, 32'd1);
      chk("issue_mem_we", {31'b0, mem_we}, {31'b0, v.we});
      chk("issue_mem_addr", {24'b0, mem_addr}, {24'b0, v.addr});
      if (v.we) chk("issue_mem_wdata", mem_wdata, v.wdata);
      chk("issue_busy", {31'b0, busy}, 32'd1);
      tick();
      chk("done_own", {31'b0, (v.who ? r1_done : r0_done)}, 32'd1);
      chk("done_other", {31'b0, (v.who ? r0_done : r1_done)}, 32'd0);
      chk("done_mem_en", {31'b0, mem_en}, 32'd0);
      chk("done_rdata", (v.who ? r1_rdata : r0_rdata), v.exp_rdata);
      idle_inputs();
      tick();
      chk("idle_done", {30'b0, r1_done, r0_done}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);
   endtask

   // Wait (bounded) for the next done pulse; report winner and cycles taken.
   task automatic wait_done(output bit who, output int cyc);
      who = 1'b0;
      cyc = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         cyc++;
         if (r0_done || r1_done) break;
      end
      if (!(r0_done || r1_done)) chk("done_timeout", 32'd0, 32'd1);
      chk("done_exclusive", {31'b0, (r0_done & r1_done)}, 32'd0);
      who = r1_done;
   endtask

   initial begin
      bit who;
      int cyc;
      bit exp_order [7];

      vecs[0] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b1, 8'h3F, 32'hA5A5A5A5, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 8'h3F, 32'h0,        32'hA5A5A5A5};
      vecs[3] = '{1'b0, 1'b1, 8'h10, 32'h12345678, 32'hDEADBEEF};
      vecs[4] = '{1'b0, 1'b0, 8'hFF, 32'h0,        32'hCAFEF00D};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'h11111111};
      vecs[6] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'h12345678};

      do_reset();
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_done", {30'b0, r1_done, r0_done}, 32'd0);
      chk("rst_r0_rdata", r0_rdata, 32'd0);
      chk("rst_r1_rdata", r1_rdata, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);

      for (int i = 0; i < 7; i++) do_access(vecs[i]);
      chk("hold_mem_addr", {24'b0, mem_addr}, 32'h10);

      // Contention, no lock: alternate starting with r0, one done per 3 cycles.
      do_reset();
      r0_req = 1; r0_addr = 8'h01;
      r1_req = 1; r1_addr = 8'h02;
      for (int k = 0; k < 6; k++) begin
         wait_done(who, cyc);
         chk("rr_winner", {31'b0, who}, (k % 2));
         chk("rr_cycles", cyc, (k == 0) ? 2 : 3);
         chk("rr_rdata", (who ? r1_rdata : r0_rdata), (who ? 32'h02020202 : 32'h01010101));
      end

      // Lock bound: r0 locked, both requesting continuously.
      do_reset();
      exp_order = '{0, 0, 0, 0, 0, 1, 0};
      r0_req = 1; r0_lock = 1; r0_addr = 8'h01;
      r1_req = 1; r1_addr = 8'h02;
      for (int k = 0; k < 7; k++) begin
         wait_done(who, cyc);
         chk("lock_winner", {31'b0, who}, {31'b0, exp_order[k]});
      end

      // Reset asserted during ISSUE of an r0 read.
      do_reset();
      r0_req = 1; r0_addr = 8'h10;
      tick();
      chk("abort_issue_en", {31'b0, mem_en}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_mem_en", {31'b0, mem_en}, 32'd0);
      chk("abort_r0_done", {31'b0, r0_done}, 32'd0);
      tick();
      chk("retry_mem_en", {31'b0, mem_en}, 32'd1);
      tick();
      chk("retry_r0_done", {31'b0, r0_done}, 32'd1);
      chk("retry_r0_rdata", r0_rdata, 32'hDEADBEEF);
      idle_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
